// File: rtl/seg_disp_pkg.sv
// seg_disp_pkg: shared widths, blank pattern and seg_array slicing for the 4-digit display path.
package seg_disp_pkg;
   localparam int NUM_DIGITS  = 4;
   localparam int SEG_W       = 7;
   localparam int SEG_ARRAY_W = 28;
   localparam logic [SEG_W-1:0] SEG_BLANK = '0;
   function automatic int digit_slice(input logic [1:0] d);
      return SEG_ARRAY_W - 1 - SEG_W * int'(d);
   endfunction
endpackage

// File: rtl/tick_div.sv
// tick_div: free-running 0..DIV-1 counter with a one-cycle tick at the terminal count.
module tick_div #(
   parameter int DIV = 2
) (
   input  logic clk,
   input  logic reset,
   output logic tick
);
   localparam int CW = $clog2(DIV);
   logic [CW-1:0] cnt;
   assign tick = cnt == CW'(DIV - 1);
   always_ff @(posedge clk) begin
      if (reset) cnt <= '0;
      else       cnt <= tick ? '0 : cnt + 1'b1;
   end
endmodule

// File: rtl/seg_scan_driver.sv
// seg_scan_driver: time-multiplexes four 7-segment digits onto shared seg/anode pins.
// Define SEG_SCAN_BLINK_EN to blink the digits marked in sel.
module seg_scan_driver
   import seg_disp_pkg::*;
#(
   parameter int REFRESH_DIV = 50000,
   parameter int BLINK_DIV   = 25000000,
   parameter bit ACTIVE_LOW  = 1'b1
) (
   input  logic                   clk,
   input  logic                   reset,
   input  logic [SEG_ARRAY_W-1:0] seg_array,
   input  logic [NUM_DIGITS-1:0]  dp_mask,
   input  logic [NUM_DIGITS-1:0]  sel,
   input  logic                   enable,
   output logic [SEG_W:0]         seg,
   output logic [NUM_DIGITS-1:0]  anode,
   output logic [1:0]             digit_idx
);
   logic refresh_tick, blank_slot;
   logic [SEG_W:0] seg_l;
   logic [NUM_DIGITS-1:0] anode_l;
   tick_div #(.DIV(REFRESH_DIV)) u_refresh (.clk(clk), .reset(reset), .tick(refresh_tick));
`ifdef SEG_SCAN_BLINK_EN
   logic blink_tick, blink_phase;
   tick_div #(.DIV(BLINK_DIV)) u_blink (.clk(clk), .reset(reset), .tick(blink_tick));
   always_ff @(posedge clk) begin
      if (reset)           blink_phase <= 1'b0;
      else if (blink_tick) blink_phase <= ~blink_phase;
   end
   assign blank_slot = blink_phase & sel[~digit_idx];
`else
   localparam int unused_blink_div = BLINK_DIV;
   logic unused_sel;
   assign unused_sel = ^sel;
   assign blank_slot = 1'b0;
`endif
   // ~digit_idx == 3-d: digit0 sits in the MSB of dp_mask, sel and anode
   always_comb begin
      seg_l   = enable ? {dp_mask[~digit_idx], seg_array[digit_slice(digit_idx) -: SEG_W]} : {1'b0, SEG_BLANK};
      anode_l = (enable && !blank_slot) ? 4'b1000 >> digit_idx : '0;
   end
   always_ff @(posedge clk) begin
      if (reset) begin
         digit_idx <= '0;
         seg       <= {(SEG_W+1){ACTIVE_LOW}};
         anode     <= {NUM_DIGITS{ACTIVE_LOW}};
      end else begin
         digit_idx <= refresh_tick ? digit_idx + 2'd1 : digit_idx;
         seg       <= seg_l ^ {(SEG_W+1){ACTIVE_LOW}};
         anode     <= anode_l ^ {NUM_DIGITS{ACTIVE_LOW}};
      end
   end
endmodule

// File: tb/tb_seg_scan_driver.sv
// tb_seg_scan_driver: directed checks of scan order, dp, blanking, blink and reset.
module tb_seg_scan_driver;
   logic clk = 1'b0, reset = 1'b1, enable = 1'b1;
   logic [27:0] seg_array;
   logic [3:0] dp_mask = 4'b0000, sel = 4'b0000;
   logic [7:0] seg;
   logic [3:0] anode;
   logic [1:0] digit_idx;
   int vectors = 0, miscompares = 0, n = 0;
   localparam logic [27:0] NUM_1234 = 28'b0000110_1011011_1001111_1100110;
   logic [6:0] pat [4] = '{7'b0000110, 7'b1011011, 7'b1001111, 7'b1100110};
   logic [3:0] an [4] = '{4'b0111, 4'b1011, 4'b1101, 4'b1110};
   always #5 clk = ~clk;
   seg_scan_driver #(.REFRESH_DIV(4), .BLINK_DIV(16), .ACTIVE_LOW(1'b1)) dut (
      .clk(clk), .reset(reset), .seg_array(seg_array), .dp_mask(dp_mask),
      .sel(sel), .enable(enable), .seg(seg), .anode(anode), .digit_idx(digit_idx)
   );
   task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
      vectors++;
      if (got !== exp) begin
         miscompares++;
         $display("FAIL %s @edge %0d: got %h expected %h", tag, n, got, exp);
      end
   endtask
   task automatic step();
      @(posedge clk);
      #1;
      n++;
   endtask
   // edge n after release shows slot ((n-1)/4)%4; blink phase flips every 16 edges
   task automatic check_scan(input string tag);
      int d = ((n - 1) / 4) % 4;
      logic ph;
      logic [3:0] ea;
      logic [7:0] es;
`ifdef SEG_SCAN_BLINK_EN
      ph = ((n - 1) / 16) % 2 == 1;
`else
      ph = 1'b0;
`endif
      ea = enable ? an[d] : 4'hF;
      if (enable && ph && sel[3-d]) ea = 4'hF;
      es = enable ? {~dp_mask[3-d], seg_array == 28'd0 ? 7'h7F : ~pat[d]} : 8'hFF;
      check({tag, "_anode"}, 8'(anode), 8'(ea));
      check({tag, "_seg"}, seg, es);
      check({tag, "_idx"}, 8'(digit_idx), 8'((n / 4) % 4));
   endtask
   task automatic run(input string tag, input int cycles);
      for (int i = 0; i < cycles; i++) begin
         step();
         check_scan(tag);
      end
   endtask
   initial begin
      seg_array = NUM_1234;
      for (int i = 0; i < 3; i++) begin
         step();
         check("rst_anode", 8'(anode), 8'hF);
         check("rst_seg", seg, 8'hFF);
         check("rst_idx", 8'(digit_idx), 8'd0);
      end
      reset = 1'b0;
      n = 0;
      step();
      check_scan("first");
      check("first_anode", 8'(anode), 8'(4'b0111));
      check("first_seg", seg, 8'b1111_1001);
      run("scan1234", 31);
      dp_mask = 4'b0100;
      run("dp", 16);
      dp_mask = 4'b0000;
      run("pre_blank", 10);
      enable = 1'b0;
      run("blank", 5);
      check("blank_anode_const", 8'(anode), 8'hF);
      enable = 1'b1;
      run("resume", 8);
      sel = 4'b1000;
      run("blink_d0", 64);
      sel = 4'b0000;
      run("no_sel", 16);
      sel = 4'b1111;
      run("blink_all", 32);
      sel = 4'b0000;
      seg_array = 28'd0;
      run("pat_zero", 4);
      seg_array = NUM_1234;
      run("pre_rst", 6);
      reset = 1'b1;
      for (int i = 0; i < 2; i++) begin
         step();
         check("midrst_anode", 8'(anode), 8'hF);
         check("midrst_seg", seg, 8'hFF);
         check("midrst_idx", 8'(digit_idx), 8'd0);
      end
      reset = 1'b0;
      n = 0;
      run("restart", 20);
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end
endmodule
